// File: rtl/mr1_mem_arbiter_pkg.sv
// Shared types for the MR1 two-to-one memory arbiter: requester ids,
// arbiter states and access-size encodings.
package mr1_arb_pkg;

    typedef enum logic {
        REQ_INSTR = 1'b0,
        REQ_DATA  = 1'b1
    } req_id_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    function automatic req_id_t other_id(input req_id_t id);
        return (id == REQ_INSTR) ? REQ_DATA : REQ_INSTR;
    endfunction

endpackage

// File: rtl/mr1_mem_arbiter_if.sv
// Bundle of the fetch, data and shared-memory buses around the arbiter.
// Handshakes: a beat transfers on the cycle where valid && ready; responses have no backpressure.
interface mr1_mem_arbiter_if;
    import mr1_arb_pkg::*;

    logic        instr_req_valid;
    logic        instr_req_ready;
    logic [31:0] instr_req_addr;
    logic        instr_rsp_valid;
    logic [31:0] instr_rsp_data;

    logic        data_req_valid;
    logic        data_req_ready;
    logic [31:0] data_req_addr;
    logic        data_req_wr;
    logic [1:0]  data_req_size;
    logic [31:0] data_req_data;
    logic        data_rsp_valid;
    logic [31:0] data_rsp_data;

    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_wr;
    logic [1:0]  mem_req_size;
    logic [31:0] mem_req_data;
    req_id_t     mem_req_id;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;

    logic        err_unexpected_rsp;
    arb_state_t  dbg_state;
    logic [4:0]  dbg_outstanding;

    modport slave (
        input  instr_req_valid, instr_req_addr,
        output instr_req_ready, instr_rsp_valid, instr_rsp_data,
        input  data_req_valid, data_req_addr, data_req_wr, data_req_size, data_req_data,
        output data_req_ready, data_rsp_valid, data_rsp_data,
        output mem_req_valid, mem_req_addr, mem_req_wr, mem_req_size, mem_req_data, mem_req_id,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output err_unexpected_rsp, dbg_state, dbg_outstanding
    );

    modport master (
        output instr_req_valid, instr_req_addr,
        input  instr_req_ready, instr_rsp_valid, instr_rsp_data,
        output data_req_valid, data_req_addr, data_req_wr, data_req_size, data_req_data,
        input  data_req_ready, data_rsp_valid, data_rsp_data,
        input  mem_req_valid, mem_req_addr, mem_req_wr, mem_req_size, mem_req_data, mem_req_id,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  err_unexpected_rsp, dbg_state, dbg_outstanding
    );

endinterface

// File: rtl/mr1_id_fifo.sv
// In-order FIFO of requester ids for reads that are accepted but not yet answered.
module mr1_id_fifo
    import mr1_arb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  req_id_t       i_push_id,
    input  logic          i_pop,
    output req_id_t       o_head_id,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    req_id_t       r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head_id = r_mem[r_rd_ptr];
    assign w_push    = i_push && !o_full;
    assign w_pop     = i_pop && !o_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= REQ_INSTR;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_id;
                r_wr_ptr        <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mr1_mem_arbiter.sv
// Shares one pipelined memory port between the MR1 fetch and data buses with
// round-robin arbitration, grant locking and in-order response routing.
module mr1_mem_arbiter
    import mr1_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic             clk,
    input  logic             reset,
    mr1_mem_arbiter_if.slave bus
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    arb_state_t    r_state;
    req_id_t       r_last_grant;
    req_id_t       r_lock_id;
    logic          r_err;

    req_id_t       w_grant;
    req_id_t       w_head_id;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic          w_req_valid;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic          w_is_data;

    // A locked grant wins over new arbitration so the presented payload stays stable.
    always_comb begin
        w_grant = REQ_INSTR;
        if (r_state == LOCKED) begin
            w_grant = r_lock_id;
        end else if (bus.instr_req_valid && bus.data_req_valid) begin
            w_grant = other_id(r_last_grant);
        end else if (bus.data_req_valid) begin
            w_grant = REQ_DATA;
        end
    end

    assign w_is_data   = (w_grant == REQ_DATA);
    assign w_req_valid = !w_full && (w_is_data ? bus.data_req_valid : bus.instr_req_valid);
    assign w_accept    = w_req_valid && bus.mem_req_ready;
    assign w_push      = w_accept && !(w_is_data && bus.data_req_wr);
    assign w_pop       = bus.mem_rsp_valid && !w_empty;

    assign bus.mem_req_valid   = w_req_valid;
    assign bus.mem_req_id      = w_grant;
    assign bus.mem_req_addr    = w_is_data ? bus.data_req_addr : bus.instr_req_addr;
    assign bus.mem_req_wr      = w_is_data ? bus.data_req_wr : 1'b0;
    assign bus.mem_req_size    = w_is_data ? bus.data_req_size : SIZE_W;
    assign bus.mem_req_data    = w_is_data ? bus.data_req_data : 32'h0;
    assign bus.instr_req_ready = w_req_valid && !w_is_data && bus.mem_req_ready;
    assign bus.data_req_ready  = w_req_valid && w_is_data && bus.mem_req_ready;

    assign bus.instr_rsp_valid    = w_pop && (w_head_id == REQ_INSTR);
    assign bus.data_rsp_valid     = w_pop && (w_head_id == REQ_DATA);
    assign bus.instr_rsp_data     = bus.mem_rsp_data;
    assign bus.data_rsp_data      = bus.mem_rsp_data;
    assign bus.err_unexpected_rsp = r_err;
    assign bus.dbg_state          = r_state;
    assign bus.dbg_outstanding    = 5'(w_count);

    mr1_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_push    (w_push),
        .i_push_id (w_grant),
        .i_pop     (w_pop),
        .o_head_id (w_head_id),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (w_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_grant <= REQ_DATA;
            r_lock_id    <= REQ_INSTR;
            r_err        <= 1'b0;
        end else begin
            if (bus.mem_rsp_valid && w_empty) r_err <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_last_grant <= w_grant;
                    end else if (w_req_valid) begin
                        r_state   <= LOCKED;
                        r_lock_id <= w_grant;
                    end
                end
                LOCKED: begin
                    if (w_accept) begin
                        r_last_grant <= w_grant;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mr1_mem_arbiter.sv
// Bench for mr1_mem_arbiter: directed scenarios plus random traffic against a
// queue-based model of arbitration, outstanding reads and response routing.
module tb_mr1_mem_arbiter;
    import mr1_arb_pkg::*;

    localparam int MAX_OUT = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mr1_mem_arbiter_if bus ();

    mr1_mem_arbiter #(
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          total = 0;
    int          bad   = 0;
    logic [32:0] exp_q [$];   // {requester id, read data} in issue order
    logic [31:0] mem_q [$];   // read data the memory still owes
    logic [31:0] forced_q [$];
    int          out_cnt;
    logic        held;
    req_id_t     held_id;
    req_id_t     last_id;
    logic        err_exp;
    logic        seen_id;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Response monitor: every routed response must match the oldest expected read.
    always @(negedge clk) begin
        if (!reset && (bus.instr_rsp_valid || bus.data_rsp_valid)) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rsp_unexpected act=%b%b exp=none t=%0t",
                         bus.instr_rsp_valid, bus.data_rsp_valid, $time);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("rsp_instr_valid", 32'(bus.instr_rsp_valid), 32'(e[32] == 1'b0));
                chk("rsp_data_valid", 32'(bus.data_rsp_valid), 32'(e[32] == 1'b1));
                chk("rsp_payload", e[32] ? bus.data_rsp_data : bus.instr_rsp_data, e[31:0]);
            end
        end
    end

    // One clock of the request-side model: check at negedge, update, advance.
    task automatic step();
        req_id_t     g;
        logic        ev, eacc, ewr, drop_i, drop_d;
        logic [31:0] ea, ed, rd;
        logic [1:0]  es;
        int          cnt0;
        drop_i = 1'b0;
        drop_d = 1'b0;
        @(negedge clk);
        cnt0 = out_cnt;
        if (held) g = held_id;
        else if (bus.instr_req_valid && bus.data_req_valid) g = (last_id == REQ_INSTR) ? REQ_DATA : REQ_INSTR;
        else if (bus.data_req_valid) g = REQ_DATA;
        else g = REQ_INSTR;
        ev   = (cnt0 < MAX_OUT) && ((g == REQ_DATA) ? bus.data_req_valid : bus.instr_req_valid);
        eacc = ev && bus.mem_req_ready;
        ea   = (g == REQ_DATA) ? bus.data_req_addr : bus.instr_req_addr;
        ewr  = (g == REQ_DATA) ? bus.data_req_wr : 1'b0;
        es   = (g == REQ_DATA) ? bus.data_req_size : SIZE_W;
        ed   = (g == REQ_DATA) ? bus.data_req_data : 32'h0;
        seen_id = bus.mem_req_id;

        chk("state", 32'(bus.dbg_state), 32'(held ? LOCKED : IDLE));
        chk("outstanding", 32'(bus.dbg_outstanding), 32'(cnt0));
        chk("mem_req_valid", 32'(bus.mem_req_valid), 32'(ev));
        chk("instr_req_ready", 32'(bus.instr_req_ready), 32'(eacc && g == REQ_INSTR));
        chk("data_req_ready", 32'(bus.data_req_ready), 32'(eacc && g == REQ_DATA));
        if (ev) begin
            chk("mem_req_id", 32'(bus.mem_req_id), 32'(g));
            chk("mem_req_addr", bus.mem_req_addr, ea);
            chk("mem_req_wr", 32'(bus.mem_req_wr), 32'(ewr));
            chk("mem_req_size", 32'(bus.mem_req_size), 32'(es));
            chk("mem_req_data", bus.mem_req_data, ed);
        end
        chk("rsp_any", 32'(bus.instr_rsp_valid || bus.data_rsp_valid), 32'(bus.mem_rsp_valid && cnt0 > 0));
        chk("instr_rsp_data", bus.instr_rsp_data, bus.mem_rsp_data);
        chk("data_rsp_data", bus.data_rsp_data, bus.mem_rsp_data);
        chk("err_unexpected", 32'(bus.err_unexpected_rsp), 32'(err_exp));

        if (bus.mem_rsp_valid && cnt0 == 0) err_exp = 1'b1;
        if (bus.mem_rsp_valid && cnt0 > 0) out_cnt--;
        if (eacc) begin
            held    = 1'b0;
            last_id = g;
            if (g == REQ_DATA) drop_d = 1'b1;
            else drop_i = 1'b1;
            if (!ewr) begin
                rd = (forced_q.size() > 0) ? forced_q.pop_front() : $urandom;
                mem_q.push_back(rd);
                exp_q.push_back({g, rd});
                out_cnt++;
            end
        end else if (ev) begin
            held    = 1'b1;
            held_id = g;
        end
        @(posedge clk);
        #1;
        bus.mem_rsp_valid = 1'b0;
        if (drop_i) bus.instr_req_valid = 1'b0;
        if (drop_d) bus.data_req_valid = 1'b0;
    endtask

    task automatic issue_rsp();
        if (mem_q.size() > 0) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = mem_q.pop_front();
        end
    endtask

    task automatic drive_instr(input logic [31:0] a);
        bus.instr_req_valid = 1'b1;
        bus.instr_req_addr  = a;
    endtask

    task automatic drive_data(input logic [31:0] a, input logic wr, input logic [1:0] sz, input logic [31:0] d);
        bus.data_req_valid = 1'b1;
        bus.data_req_addr  = a;
        bus.data_req_wr    = wr;
        bus.data_req_size  = sz;
        bus.data_req_data  = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.instr_req_valid = 1'b0;
        bus.instr_req_addr  = '0;
        bus.data_req_valid  = 1'b0;
        bus.data_req_addr   = '0;
        bus.data_req_wr     = 1'b0;
        bus.data_req_size   = SIZE_B;
        bus.data_req_data   = '0;
        bus.mem_req_ready   = 1'b0;
        bus.mem_rsp_valid   = 1'b0;
        bus.mem_rsp_data    = '0;
        exp_q.delete();
        mem_q.delete();
        out_cnt = 0;
        held    = 1'b0;
        held_id = REQ_INSTR;
        last_id = REQ_DATA;
        err_exp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        step();
    endtask

    task automatic drain();
        bus.instr_req_valid = 1'b0;
        bus.data_req_valid  = 1'b0;
        for (int k = 0; k < 64 && mem_q.size() > 0; k++) begin
            issue_rsp();
            step();
        end
        step();
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        // Single fetch answered three cycles after acceptance.
        do_reset();
        forced_q.push_back(32'hDEAD_BEEF);
        bus.mem_req_ready = 1'b1;
        drive_instr(32'h100);
        step();
        step();
        step();
        issue_rsp();
        step();

        // Round-robin under constant conflict.
        do_reset();
        bus.mem_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (!bus.instr_req_valid) drive_instr(32'h1000 + 32'(i * 4));
            if (!bus.data_req_valid) drive_data(32'h8000 + 32'(i * 4), 1'b1, SIZE_W, $urandom);
            step();
            chk("conflict_grant", 32'(seen_id), 32'(i % 2));
        end
        drain();

        // Grant locked on a stalled store while the fetch waits.
        do_reset();
        drive_data(32'h2000, 1'b1, SIZE_H, 32'h1234_5678);
        step();
        drive_instr(32'h300);
        step();
        step();
        bus.mem_req_ready = 1'b1;
        step();
        chk("lock_store_first", 32'(seen_id), 32'(REQ_DATA));
        step();
        chk("lock_instr_next", 32'(seen_id), 32'(REQ_INSTR));
        drain();

        // Full id FIFO blocks the fifth read until a response frees a slot.
        do_reset();
        bus.mem_req_ready = 1'b1;
        for (int i = 0; i < MAX_OUT; i++) begin
            drive_instr(32'h400 + 32'(i * 4));
            step();
        end
        drive_data(32'h500, 1'b0, SIZE_B, 32'h0);
        step();
        issue_rsp();
        step();
        step();
        drain();

        // In-order routing, then a stray response sets the sticky error.
        do_reset();
        forced_q.push_back(32'h1);
        forced_q.push_back(32'h2);
        forced_q.push_back(32'h3);
        bus.mem_req_ready = 1'b1;
        drive_instr(32'h600);
        step();
        drive_data(32'h604, 1'b0, SIZE_W, 32'h0);
        step();
        drive_data(32'h608, 1'b0, SIZE_W, 32'h0);
        step();
        for (int i = 0; i < 3; i++) begin
            issue_rsp();
            step();
        end
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'hBAD0_0001;
        step();
        step();
        step();
        do_reset();

        // Random traffic with random memory stalls and response timing.
        bus.mem_req_ready = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            if (!bus.instr_req_valid && $urandom_range(0, 2) == 0)
                drive_instr($urandom & 32'hFFFF_FFFC);
            if (!bus.data_req_valid && $urandom_range(0, 2) == 0)
                drive_data($urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), $urandom);
            bus.mem_req_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) issue_rsp();
            step();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mr1_mem_arbiter.md
# mr1_mem_arbiter

Two-to-one memory port arbiter for the MR1 core. It shares a single pipelined memory port between the instruction fetch bus and the data bus. Responses return in order and are routed back to the requester that issued each read. Sits between MR1 and the single-port memory/bus fabric; the formal wrapper binds it so the core's two buses can be checked against one constrained memory model.

## Interface
- `MAX_OUTSTANDING`, 4: maximum accepted-but-unanswered reads (1..16).
- `clk` in 1: sole clock.
- `reset` in 1: asynchronous, active-high.
- `instr_req_valid` in 1; `instr_req_ready` out 1; `instr_req_addr` in 32: fetch request, read-only.
- `instr_rsp_valid` out 1; `instr_rsp_data` out 32: fetch response, no backpressure.
- `data_req_valid` in 1; `data_req_ready` out 1; `data_req_addr` in 32; `data_req_wr` in 1; `data_req_size` in 2; `data_req_data` in 32: load/store request.
- `data_rsp_valid` out 1; `data_rsp_data` out 32: load response, no backpressure.
- `mem_req_valid` out 1; `mem_req_ready` in 1; `mem_req_addr` out 32; `mem_req_wr` out 1; `mem_req_size` out 2; `mem_req_data` out 32: shared memory request.
- `mem_req_id` out 1: requester of the current request; debug/formal only.
- `mem_rsp_valid` in 1; `mem_rsp_data` in 32: shared memory response, in order, reads only.
- `err_unexpected_rsp` out 1: sticky; set by a response with nothing outstanding.

## Operation
- Request acceptance: a request is accepted when `mem_req_valid && mem_req_ready`. Only the granted requester sees `*_req_ready = mem_req_ready`; the other requester's ready is 0.
- Instr requests drive `mem_req_wr=0`, `mem_req_size=2'b10` and `mem_req_data=0`.
- Arbiter state machine, IDLE / LOCKED:
  - IDLE: if one requester is valid, grant it. If both are valid, grant the one not in `last_grant` (round-robin).
  - IDLE to LOCKED: the granted request is presented but not accepted. In LOCKED the grant is frozen until acceptance, so the payload and `mem_req_id` stay stable.
  - Acceptance in either state: update `last_grant` and return to IDLE.
- Outstanding tracking:
  - Each accepted read pushes its requester id into an in-order id FIFO of depth `MAX_OUTSTANDING`.
  - Writes are not pushed and produce no response.
  - FIFO full forces `mem_req_valid=0` and both readies to 0. A pop in the same cycle does not lift the block.
  - A LOCKED grant is held across the full condition.
- Response routing:
  - `mem_rsp_valid` with a non-empty FIFO pops the head. It drives exactly one of `instr_rsp_valid`/`data_rsp_valid`, selected by the head id.
  - Both `*_rsp_data` outputs always equal `mem_rsp_data`.
  - `mem_rsp_valid` with an empty FIFO produces no response and sets `err_unexpected_rsp`. A push in the same cycle does not count as non-empty.
- Simultaneous push and pop (not full, not empty): the count is unchanged and ordering is preserved.
- Count is `$clog2(MAX_OUTSTANDING+1)` bits. Read and write pointers wrap modulo `MAX_OUTSTANDING`.

## Timing
- Request path is combinational: requester valid to `mem_req_valid`, payload mux, and `mem_req_ready` to requester ready. There are no added request cycles.
- Response path is combinational, zero latency: `mem_rsp_valid` to `*_rsp_valid` in the same cycle.
- Registered state: FSM, `last_grant`, FIFO storage and pointers, count, error flag.
- Reset values:
  - FSM = IDLE.
  - `last_grant` = data, so instr wins the first conflict.
  - FIFO empty, `err_unexpected_rsp=0`.
  - All outputs derived from this state, so the valids and readies are 0 while requester valids are 0.
- Reset mid-operation clears the outstanding state. Responses arriving after reset for pre-reset reads set the error flag; the bench must quiesce memory across reset.

## Structure
- Package `mr1_arb_pkg` holds:
  - `req_id_t` enum: `REQ_INSTR=1'b0`, `REQ_DATA=1'b1`.
  - `arb_state_t` enum: `IDLE`, `LOCKED`.
  - Size constants: `SIZE_B=2'b00`, `SIZE_H=2'b01`, `SIZE_W=2'b10`.
- Sub-module `mr1_id_fifo`: parameterised depth, 1-bit data, push/pop/full/empty/count. The arbiter FSM and muxing stay in `mr1_mem_arbiter`.

## Test plan
- Single fetch: instr addr `0x100` accepted cycle 0. Memory returns `0xDEADBEEF` cycle 3, giving `instr_rsp_valid=1` and `instr_rsp_data=0xDEADBEEF` in cycle 3, `data_rsp_valid=0`.
- Conflict: both valid, `mem_req_ready=1` for 4 cycles. Grants must be instr, data, instr, data.
- Lock: data store wins, `mem_req_ready=0` for 3 cycles while instr is valid. `mem_req_wr/addr` stay constant and `instr_req_ready=0`. The store is accepted at ready; instr is granted next.
- Full: `MAX_OUTSTANDING=4`, 4 reads issued with no response, so `mem_req_valid=0`. A response returns to the first requester and the 5th request issues the following cycle.
- Ordering: issue instr, data, data reads with responses `0x1`, `0x2`, `0x3`. The routes must be instr:`0x1`, data:`0x2`, data:`0x3`. A stray `mem_rsp_valid` afterwards sets `err_unexpected_rsp`, which holds until `reset`.
